// File: rtl/short_circuit_pkg.sv
// short_circuit_pkg: shared select encodings and in-flight slot type for the forwarding unit
package short_circuit_pkg;
  localparam int DEFAULT_SC_REG_ADDR_SIZE = 5;
  localparam int DEFAULT_SC_SEL_SIZE = 2;
  localparam logic [1:0] SC_SEL_BUS = 2'b00;
  localparam logic [1:0] SC_SEL_WB = 2'b01;
  localparam logic [1:0] SC_SEL_ALU = 2'b10;
  localparam logic [DEFAULT_SC_REG_ADDR_SIZE-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [DEFAULT_SC_REG_ADDR_SIZE-1:0] addr;
    logic reg_write;
    logic mem_read;
  } sc_slot_t;
  localparam sc_slot_t SC_BUBBLE = '0;
endpackage

// File: rtl/short_circuit_unit_compare.sv
// sc_slot_compare: next forwarding select for one operand, youngest producer first
module sc_slot_compare
  import short_circuit_pkg::*;
(
  input  logic [DEFAULT_SC_REG_ADDR_SIZE-1:0] addr_i,
  input  logic                                use_i,
  input  sc_slot_t                            ex_slot_i,
  input  sc_slot_t                            mem_slot_i,
  output logic [DEFAULT_SC_SEL_SIZE-1:0]      sel_o
);
  logic ex_hit, mem_hit;
  // a load in EX has no data yet; it is caught by the stall, not forwarded
  assign ex_hit = use_i && ex_slot_i.reg_write && !ex_slot_i.mem_read &&
                  ex_slot_i.addr != REG_ZERO && addr_i == ex_slot_i.addr;
  assign mem_hit = use_i && mem_slot_i.reg_write &&
                   mem_slot_i.addr != REG_ZERO && addr_i == mem_slot_i.addr;
  always_comb sel_o = ex_hit ? SC_SEL_ALU : mem_hit ? SC_SEL_WB : SC_SEL_BUS;
endmodule

// File: rtl/short_circuit_unit.sv
// short_circuit_unit: registered EX forwarding selects and load-use stall from a shadow of in-flight writers
module short_circuit_unit
  import short_circuit_pkg::*;
#(
  parameter int REG_ADDR_SIZE = DEFAULT_SC_REG_ADDR_SIZE,
  parameter int SEL_SIZE = DEFAULT_SC_SEL_SIZE
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_halt,
  input  logic                     i_flush,
  input  logic [REG_ADDR_SIZE-1:0] i_id_rs,
  input  logic [REG_ADDR_SIZE-1:0] i_id_rt,
  input  logic                     i_id_use_rs,
  input  logic                     i_id_use_rt,
  input  logic [REG_ADDR_SIZE-1:0] i_id_wb_addr,
  input  logic                     i_id_reg_write,
  input  logic                     i_id_mem_read,
  output logic [SEL_SIZE-1:0]      o_sc_src_a,
  output logic [SEL_SIZE-1:0]      o_sc_src_b,
  output logic                     o_stall,
  output logic [REG_ADDR_SIZE+1:0] o_wb_slot
);
  sc_slot_t ex_q, mem_q, wb_q, ex_d;
  logic [SEL_SIZE-1:0] sel_a_d, sel_b_d, sel_a_q, sel_b_q;
  logic bubble;
  sc_slot_compare u_cmp_a (
    .addr_i(i_id_rs), .use_i(i_id_use_rs), .ex_slot_i(ex_q), .mem_slot_i(mem_q), .sel_o(sel_a_d)
  );
  sc_slot_compare u_cmp_b (
    .addr_i(i_id_rt), .use_i(i_id_use_rt), .ex_slot_i(ex_q), .mem_slot_i(mem_q), .sel_o(sel_b_d)
  );
  assign o_stall = !i_halt && ex_q.mem_read && ex_q.reg_write && ex_q.addr != REG_ZERO &&
                   ((i_id_use_rs && i_id_rs == ex_q.addr) || (i_id_use_rt && i_id_rt == ex_q.addr));
  assign bubble = o_stall || i_flush;
  assign ex_d = bubble ? SC_BUBBLE : sc_slot_t'{i_id_wb_addr, i_id_reg_write, i_id_mem_read};
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      ex_q <= SC_BUBBLE;
      mem_q <= SC_BUBBLE;
      wb_q <= SC_BUBBLE;
      sel_a_q <= SC_SEL_BUS;
      sel_b_q <= SC_SEL_BUS;
    end else if (!i_halt) begin
      ex_q <= ex_d;
      mem_q <= ex_q;
      wb_q <= mem_q;
      sel_a_q <= bubble ? SC_SEL_BUS : sel_a_d;
      sel_b_q <= bubble ? SC_SEL_BUS : sel_b_d;
    end
  assign o_sc_src_a = sel_a_q;
  assign o_sc_src_b = sel_b_q;
  assign o_wb_slot = wb_q;
endmodule

// File: tb/tb_short_circuit_unit.sv
// tb_short_circuit_unit: directed hazard scenarios plus random traffic against an in-flight list model
module tb_short_circuit_unit;
  typedef struct packed {
    logic [4:0] rs, rt, wb;
    logic urs, urt, rw, mr;
  } ins_t;
  logic i_clk = 0, i_reset = 1, i_halt = 0, i_flush = 0;
  ins_t cur = '0;
  logic [1:0] o_sc_src_a, o_sc_src_b;
  logic o_stall;
  logic [6:0] o_wb_slot;
  int errs = 0, checks = 0;
  bit go = 0;
  ins_t m [3];
  logic [1:0] exp_a = 0, exp_b = 0;
  always #5 i_clk = ~i_clk;
  short_circuit_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt), .i_flush(i_flush),
    .i_id_rs(cur.rs), .i_id_rt(cur.rt), .i_id_use_rs(cur.urs), .i_id_use_rt(cur.urt),
    .i_id_wb_addr(cur.wb), .i_id_reg_write(cur.rw), .i_id_mem_read(cur.mr),
    .o_sc_src_a(o_sc_src_a), .o_sc_src_b(o_sc_src_b), .o_stall(o_stall), .o_wb_slot(o_wb_slot)
  );
  // m[0] is the instruction in EX, m[1] in MEM, m[2] in WB; the youngest matching writer decides
  function automatic logic [1:0] want(input logic [4:0] a, input logic u);
    for (int k = 0; k < 2; k++)
      if (u && m[k].rw && m[k].wb != 0 && m[k].wb == a) return k == 0 ? (m[k].mr ? 2'b00 : 2'b10) : 2'b01;
    return 2'b00;
  endfunction
  function automatic logic stall_m();
    return !i_halt && m[0].rw && m[0].mr && m[0].wb != 0 &&
           ((cur.urs && cur.rs == m[0].wb) || (cur.urt && cur.rt == m[0].wb));
  endfunction
  function automatic ins_t mk(input int rs, input int rt, input int wb, input bit urs, input bit urt, input bit rw, input bit mr);
    ins_t x;
    x.rs = 5'(rs); x.rt = 5'(rt); x.wb = 5'(wb);
    x.urs = urs; x.urt = urt; x.rw = rw; x.mr = mr;
    return x;
  endfunction
  function automatic ins_t addi(input int d, input int s); return mk(s, 0, d, 1, 0, 1, 0); endfunction
  function automatic ins_t add(input int d, input int s, input int t); return mk(s, t, d, 1, 1, 1, 0); endfunction
  function automatic ins_t lw(input int d, input int s); return mk(s, 0, d, 1, 0, 1, 1); endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask
  task automatic tick(); @(posedge i_clk); #2; endtask
  task automatic set(input ins_t x); cur = x; #1; endtask
  always @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      for (int k = 0; k < 3; k++) m[k] <= '0;
      exp_a <= 0;
      exp_b <= 0;
    end else if (!i_halt) begin
      exp_a <= (stall_m() || i_flush) ? 2'b00 : want(cur.rs, cur.urs);
      exp_b <= (stall_m() || i_flush) ? 2'b00 : want(cur.rt, cur.urt);
      m[0] <= (stall_m() || i_flush) ? '0 : cur;
      m[1] <= m[0];
      m[2] <= m[1];
    end
  always @(negedge i_clk)
    if (go) begin
      chk("model_stall", int'(o_stall), int'(stall_m()));
      chk("model_src_a", int'(o_sc_src_a), int'(exp_a));
      chk("model_src_b", int'(o_sc_src_b), int'(exp_b));
      chk("model_wb_ctl", int'(o_wb_slot[1:0]), int'({m[2].rw, m[2].mr}));
      if (m[2].rw) chk("model_wb_addr", int'(o_wb_slot[6:2]), int'(m[2].wb));
    end
  initial begin
    #1 i_reset = 0;
    #1;
    chk("rst_a", int'(o_sc_src_a), 0);
    chk("rst_b", int'(o_sc_src_b), 0);
    chk("rst_stall", int'(o_stall), 0);
    #11 i_reset = 1;
    go = 1;
    tick();
    set(addi(3, 1)); tick();
    set(add(4, 3, 5));
    chk("t2_stall", int'(o_stall), 0);
    tick();
    chk("t2_a", int'(o_sc_src_a), 2);
    chk("t2_b", int'(o_sc_src_b), 0);
    set(addi(3, 1)); tick();
    set('0); tick();
    set(add(6, 7, 3)); tick();
    chk("t3_a", int'(o_sc_src_a), 0);
    chk("t3_b", int'(o_sc_src_b), 1);
    set(lw(8, 1)); tick();
    set(add(9, 8, 8));
    chk("t4_stall", int'(o_stall), 1);
    tick();
    chk("t4_bub_a", int'(o_sc_src_a), 0);
    chk("t4_bub_b", int'(o_sc_src_b), 0);
    chk("t4_unstall", int'(o_stall), 0);
    tick();
    chk("t4_a", int'(o_sc_src_a), 1);
    chk("t4_b", int'(o_sc_src_b), 1);
    set(addi(2, 1)); tick();
    set(addi(2, 1)); tick();
    set(add(1, 2, 2)); tick();
    chk("t5_young_a", int'(o_sc_src_a), 2);
    chk("t5_young_b", int'(o_sc_src_b), 2);
    set(addi(0, 1)); tick();
    set(add(1, 0, 0)); tick();
    chk("t5_zero_a", int'(o_sc_src_a), 0);
    chk("t5_zero_b", int'(o_sc_src_b), 0);
    set('0); tick(); tick();
    set(addi(3, 1)); tick();
    i_halt = 1;
    set(add(4, 3, 5));
    repeat (3) begin
      tick();
      chk("t6_halt_a", int'(o_sc_src_a), 0);
    end
    i_halt = 0;
    tick();
    chk("t6_resume_a", int'(o_sc_src_a), 2);
    set('0); tick(); tick();
    set(lw(8, 1)); tick();
    i_halt = 1;
    set(add(9, 8, 8));
    chk("t6_halt_stall", int'(o_stall), 0);
    tick();
    chk("t6_halt_stall2", int'(o_stall), 0);
    i_halt = 0;
    #1 chk("t6_stall", int'(o_stall), 1);
    tick(); tick();
    chk("t6_ld_a", int'(o_sc_src_a), 1);
    set('0); tick(); tick();
    i_flush = 1;
    set(addi(3, 1)); tick();
    i_flush = 0;
    set(add(4, 3, 3)); tick();
    chk("t6_flush_a", int'(o_sc_src_a), 0);
    chk("t6_flush_b", int'(o_sc_src_b), 0);
    set(addi(5, 1)); tick();
    set(lw(6, 1)); tick();
    set(add(7, 6, 5));
    chk("t1_pre_stall", int'(o_stall), 1);
    i_reset = 0;
    #1;
    chk("t1_stall", int'(o_stall), 0);
    chk("t1_a", int'(o_sc_src_a), 0);
    chk("t1_b", int'(o_sc_src_b), 0);
    tick();
    i_reset = 1;
    tick();
    chk("t1_stale_a", int'(o_sc_src_a), 0);
    chk("t1_stale_b", int'(o_sc_src_b), 0);
    repeat (3000) begin
      cur = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      i_halt = $urandom_range(0, 9) == 0;
      i_flush = $urandom_range(0, 9) == 0;
      tick();
    end
    i_halt = 0;
    i_flush = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
